grant_transfer_unit: RTL and testbench
======================================

Name: grant_transfer_unit

Overview:
Downstream consumer of the 3-way arbiter's one-hot grant vector g[1:3]. When a client holds a grant, this block latches that client's data word and drives it onto a shared bus for a fixed number of cycles. It then pulses done to that client so the client drops its request, and waits for the grant to be released. It also counts completed transfers and flags illegal or aborted grants.

Parameters:
WIDTH, 8, data word width of each client and of the bus
XFER_CYCLES, 4, cycles bus_valid is held per transfer (legal range 1..255)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Resetn  input  1  asynchronous active-low reset
g  input  [1:3]  one-hot grant from arbiter; g[i] high = client i owns bus
d1  input  WIDTH  client 1 data word
d2  input  WIDTH  client 2 data word
d3  input  WIDTH  client 3 data word
bus_data  output  WIDTH  registered data driven to shared resource
bus_valid  output  1  bus_data valid this cycle
bus_src  output  2  source of current transfer (1..3), 0 when idle
done  output  [1:3]  one-cycle completion pulse to client i
busy  output  1  high in any state other than IDLE
xfer_count  output  8  completed-transfer counter
err  output  1  sticky illegal-grant / abort flag

Behaviour:
- Reset: Clock and Resetn as listed; reset is asynchronous and active-low. While Resetn=0, immediately force state=IDLE, bus_data=0, bus_valid=0, bus_src=0, done=000, busy=0, xfer_count=0, err=0, cycle counter=0. Reset mid-transfer aborts it with no done pulse.
- All outputs are registered (Moore); no combinational path from g or d* to any output.
- States: IDLE, XFER, DONE, WAIT.
- IDLE:
  - g one-hot at a rising edge: latch d<i> into bus_data, set bus_src=i, load the cycle counter with XFER_CYCLES-1, go to XFER. bus_valid=1 from the next cycle.
  - g=000: stay in IDLE.
  - g with more than one bit set: set err=1, stay in IDLE, latch nothing.
- XFER:
  - bus_valid=1, and bus_data stays constant (the d* inputs are not re-sampled).
  - The counter decrements each edge. At an edge where counter=0 and g[bus_src]=1, go to DONE. bus_valid is therefore high for exactly XFER_CYCLES cycles.
  - If g[bus_src]=0 at any XFER edge (grant lost), abort: set err=1, go to IDLE, clear bus_valid and bus_src, give no done pulse and no count increment.
- DONE (exactly one cycle):
  - done[bus_src]=1, bus_valid=0.
  - xfer_count increments on entry, wrapping 255 -> 0.
  - Next edge goes to WAIT.
- WAIT:
  - done=000, busy=1.
  - Stay in WAIT while g[bus_src]=1. When g[bus_src]=0, go to IDLE and clear bus_src.
  - A different grant bit going high while in WAIT is ignored; it is re-sampled in IDLE.
- Latency:
  - Grant seen at edge T: bus_valid high in cycles T+1..T+XFER_CYCLES.
  - done pulse in cycle T+XFER_CYCLES+1.
  - Earliest return to IDLE is edge T+XFER_CYCLES+2, if the grant drops immediately.
- Back-to-back transfers: WAIT -> IDLE -> XFER needs one IDLE cycle. This matches the arbiter, which passes through its Idle state between grants.
- err clears only on reset.
- busy = (state != IDLE).

Test Plan:
- Reset asserted asynchronously mid-XFER (between clock edges) -> all outputs 0 immediately, state IDLE, no done pulse.
- Client 2 transfer: d2=8'hA5, g=010 held until done, XFER_CYCLES=4 -> bus_valid high exactly 4 cycles with bus_data=A5 and bus_src=2; done=010 for 1 cycle; xfer_count 0->1; return to IDLE 1 cycle after g drops.
- Data stability: d1 changes every cycle during a client-1 transfer -> bus_data holds the value sampled at the grant edge for all 4 valid cycles.
- Abort: g=001, then g drops to 000 after 2 valid cycles -> bus_valid falls the next cycle, err=1, done stays 000, xfer_count unchanged.
- Illegal grant: g=110 in IDLE -> err=1, state stays IDLE, bus_valid=0; a subsequent legal g=100 still completes normally.
- Counter wrap: 256 back-to-back transfers alternating clients 1 and 3 -> xfer_count reads 255 then 0; each transfer produces a done pulse only on the granted bit.

Source files
------------

// File: rtl/grant_transfer_unit.sv
`default_nettype none
// ==== grant_transfer_unit : drives the granted client's word onto a shared bus ====
// ==== for XFER_CYCLES cycles, pulses done, counts transfers, flags bad grants. rev 1.0 ====
module grant_transfer_unit #(
  parameter int WIDTH       = 8,
  parameter int XFER_CYCLES = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [1:3]       g,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_valid,
  output logic [1:0]       bus_src,
  output logic [1:3]       done,
  output logic             busy,
  output logic [7:0]       xfer_count,
  output logic             err
);

  localparam logic [7:0] c_CNT_INIT = 8'(XFER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic [1:0]       r_src, w_src_nxt;
  logic [1:3]       r_done, w_done_nxt;
  logic             r_busy;
  logic [7:0]       r_count, w_count_nxt;
  logic             r_err, w_err_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;

  logic             w_own;
  logic             w_onehot;
  logic             w_multi;
  logic [1:0]       w_sel_src;
  logic [WIDTH-1:0] w_sel_data;
  logic [1:3]       w_src_vec;

  // Grant still held by the client currently owning the transfer
  always_comb begin
    w_own = 1'b0;
    case (r_src)
      2'd1:    w_own = g[1];
      2'd2:    w_own = g[2];
      2'd3:    w_own = g[3];
      default: w_own = 1'b0;
    endcase
  end

  always_comb begin
    w_src_vec = 3'b000;
    case (r_src)
      2'd1:    w_src_vec = 3'b100;
      2'd2:    w_src_vec = 3'b010;
      2'd3:    w_src_vec = 3'b001;
      default: w_src_vec = 3'b000;
    endcase
  end

  always_comb begin
    w_onehot   = 1'b0;
    w_sel_src  = 2'd0;
    w_sel_data = '0;
    case (g)
      3'b100: begin w_onehot = 1'b1; w_sel_src = 2'd1; w_sel_data = d1; end
      3'b010: begin w_onehot = 1'b1; w_sel_src = 2'd2; w_sel_data = d2; end
      3'b001: begin w_onehot = 1'b1; w_sel_src = 2'd3; w_sel_data = d3; end
      default: begin w_onehot = 1'b0; w_sel_src = 2'd0; w_sel_data = '0; end
    endcase
    w_multi = (g != 3'b000) && !w_onehot;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_src_nxt   = r_src;
    w_done_nxt  = 3'b000;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_data_nxt  = w_sel_data;
          w_src_nxt   = w_sel_src;
          w_cnt_nxt   = c_CNT_INIT;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_XFER;
        end else if (w_multi) begin
          w_err_nxt = 1'b1;
        end
      end
      S_XFER: begin
        // Losing the grant mid-transfer is an abort, checked before completion
        if (!w_own) begin
          w_err_nxt   = 1'b1;
          w_valid_nxt = 1'b0;
          w_src_nxt   = 2'd0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = w_src_vec;
          w_count_nxt = r_count + 8'd1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!w_own) begin
          w_src_nxt   = 2'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_src   <= 2'd0;
      r_done  <= 3'b000;
      r_busy  <= 1'b0;
      r_count <= 8'd0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_src   <= w_src_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus_data   = r_data;
  assign bus_valid  = r_valid;
  assign bus_src    = r_src;
  assign done       = r_done;
  assign busy       = r_busy;
  assign xfer_count = r_count;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_grant_transfer_unit.sv
`default_nettype none
// ==== tb_grant_transfer_unit : directed + random stimulus against a transfer-level model ====
module tb_grant_transfer_unit;
  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:3]   g;
  logic [W-1:0] d1, d2, d3;
  logic [W-1:0] bus_data;
  logic         bus_valid;
  logic [1:0]   bus_src;
  logic [1:3]   done;
  logic         busy;
  logic [7:0]   xfer_count;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  grant_transfer_unit #(.WIDTH(W), .XFER_CYCLES(N)) dut (
    .Clock(clk), .Resetn(rst_n), .g(g), .d1(d1), .d2(d2), .d3(d3),
    .bus_data(bus_data), .bus_valid(bus_valid), .bus_src(bus_src),
    .done(done), .busy(busy), .xfer_count(xfer_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: m_src = owning client (0 none), m_t = edges elapsed since the grant edge.
  // Valid while m_t < N, done when m_t == N, waiting for release when m_t > N.
  int         m_src = 0;
  int         m_t   = 0;
  int         pc;
  logic [7:0] m_cnt = 8'd0;
  logic       m_err = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [1:3] e_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_src = 0; m_t = 0; m_cnt = 8'd0; m_err = 1'b0; m_data = '0;
    end else if (m_src == 0) begin
      pc = int'(g[1]) + int'(g[2]) + int'(g[3]);
      if (pc == 1) begin
        m_src  = g[1] ? 1 : (g[2] ? 2 : 3);
        m_data = (m_src == 1) ? d1 : ((m_src == 2) ? d2 : d3);
        m_t    = 0;
      end else if (pc > 1) begin
        m_err = 1'b1;
      end
    end else if (m_t < N) begin
      if (!g[m_src]) begin
        m_err = 1'b1;
        m_src = 0;
      end else begin
        m_t++;
        if (m_t == N) m_cnt = 8'((int'(m_cnt) + 1) % 256);
      end
    end else if (m_t == N) begin
      m_t++;
    end else if (!g[m_src]) begin
      m_src = 0;
    end
    #1;
    if (chk_en) begin
      e_done = 3'b000;
      if (m_src != 0 && m_t == N) e_done[m_src] = 1'b1;
      chk("bus_valid", 32'(bus_valid), 32'(m_src != 0 && m_t < N));
      chk("bus_src", 32'(bus_src), 32'(m_src));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(m_src != 0));
      chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      if (m_src != 0 && m_t < N) chk("bus_data", 32'(bus_data), 32'(m_data));
    end
  end

  task automatic do_xfer(input int c);
    logic [1:3] v;
    bit ok;
    v = 3'b000;
    v[c] = 1'b1;
    g = v;
    ok = 1'b0;
    for (int k = 0; k < N + 10; k++) begin
      @(negedge clk);
      if (done != 3'b000) begin ok = 1'b1; break; end
    end
    chk("xfer_done_seen", 32'(ok), 32'd1);
    chk("xfer_done_bit", 32'(done), 32'(v));
    g = 3'b000;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("xfer_release", 32'(ok), 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    g = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b0; g = 3'b000; d1 = '0; d2 = '0; d3 = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Client 2 transfer with hand-computed expectations
    d2 = 8'hA5; g = 3'b010;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("c2_valid", 32'(bus_valid), 32'd1);
      chk("c2_data", 32'(bus_data), 32'hA5);
      chk("c2_src", 32'(bus_src), 32'd2);
    end
    @(negedge clk);
    chk("c2_done", 32'(done), 32'(3'b010));
    chk("c2_count", 32'(xfer_count), 32'd1);
    chk("c2_valid_off", 32'(bus_valid), 32'd0);
    g = 3'b000;
    @(negedge clk);
    chk("c2_wait_busy", 32'(busy), 32'd1);
    chk("c2_wait_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("c2_idle", 32'(busy), 32'd0);

    // Client 1 with d1 changing every cycle
    d1 = 8'h3C; g = 3'b100;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("c1_data_hold", 32'(bus_data), 32'h3C);
      d1 = 8'($urandom);
    end
    @(negedge clk);
    chk("c1_done", 32'(done), 32'(3'b100));
    chk("c1_count", 32'(xfer_count), 32'd2);
    g = 3'b000;
    repeat (2) @(negedge clk);

    // Abort after two valid cycles
    g = 3'b001;
    repeat (2) @(negedge clk);
    g = 3'b000;
    @(negedge clk);
    chk("abort_valid", 32'(bus_valid), 32'd0);
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_count", 32'(xfer_count), 32'd2);
    @(negedge clk);

    // Asynchronous reset between edges, mid-transfer
    g = 3'b010;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_valid), 32'd0);
    chk("arst_src", 32'(bus_src), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_data", 32'(bus_data), 32'd0);
    @(negedge clk);
    g = 3'b000;
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal grant, then a legal one still completes
    g = 3'b110;
    @(negedge clk);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_busy", 32'(busy), 32'd0);
    chk("illegal_valid", 32'(bus_valid), 32'd0);
    g = 3'b000;
    @(negedge clk);
    do_xfer(1);
    chk("illegal_then_ok", 32'(xfer_count), 32'd1);

    // Counter wrap: 256 transfers alternating clients 1 and 3
    reset_pulse();
    for (int i = 0; i < 256; i++) begin
      do_xfer((i % 2 == 1) ? 3 : 1);
      if (i == 254) chk("wrap_255", 32'(xfer_count), 32'd255);
      if (i == 255) chk("wrap_0", 32'(xfer_count), 32'd0);
    end

    // Random phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else if (r < 14) begin
        case ($urandom_range(0, 9))
          0, 1: g = 3'b100;
          2, 3: g = 3'b010;
          4, 5: g = 3'b001;
          6, 7, 8: g = 3'b000;
          default: g = 3'($urandom_range(3, 7)) | 3'b011;
        endcase
      end
    end
    g = 3'b000;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
